// File: rtl/mem_wb_stage.sv
// Memory stage and MEM/WB pipeline register: req/ack data-memory access with watchdog,
// store lane steering, load alignment/extension. Optional MEM_MISALIGN_TRAP_EN adds a misalign trap.
module mem_wb_stage #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memtoreg_in,
    input  logic        regwrite_in,
    input  logic        memread_in,
    input  logic        memwrite_in,
    input  logic [1:0]  aj_control_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] store_data_in,
    input  logic [2:0]  funct3_in,
    input  logic [4:0]  rd_in,
    input  logic [31:0] pc_plus4_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_out,
    output logic        bus_err,
    output logic        regwrite_wb,
    output logic        memtoreg_wb,
    output logic [4:0]  rd_wb,
    output logic [31:0] wb_data
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);

    localparam logic [7:0] MaxWait = 8'(MAX_WAIT);

    typedef enum logic {StIdle, StWait} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        access, access_eff, misalign, abort, kill;
    logic [1:0]  off;
    logic [3:0]  strb;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_data, wb_sel;

    assign access = memread_in | memwrite_in;
    assign off    = alu_result_in[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = access & (((funct3_in[1:0] == 2'b01) & off[0]) |
                                (funct3_in[1] & (off != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    assign access_eff = access & ~misalign;
    // Watchdog expires on the cycle the counter reaches MaxWait with no ack.
    assign abort      = (state_q == StWait) & ~dmem_ack & (cnt_q == MaxWait);
    assign stall_out  = access_eff & ~dmem_ack & ~abort;
    assign kill       = stall_out | abort | misalign;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (access_eff && !dmem_ack) begin
                    state_d = StWait;
                    cnt_d   = 8'd1;
                end
            end
            StWait: begin
                if (dmem_ack || abort || !access_eff) begin
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
            end
        endcase
    end

    assign dmem_req  = access_eff | (state_q == StWait);
    assign dmem_we   = memwrite_in;
    assign dmem_addr = {alu_result_in[31:2], 2'b00};

    always_comb begin
        strb       = 4'b1111;
        dmem_wdata = store_data_in;
        case (funct3_in[1:0])
            2'b00: begin
                strb       = 4'b0001 << off;
                dmem_wdata = {4{store_data_in[7:0]}};
            end
            2'b01: begin
                strb       = off[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{store_data_in[15:0]}};
            end
            default: ;
        endcase
    end

    assign dmem_wstrb = memwrite_in ? strb : 4'b0000;

    always_comb begin
        ld_byte = dmem_rdata[7:0];
        case (off)
            2'd0: ld_byte = dmem_rdata[7:0];
            2'd1: ld_byte = dmem_rdata[15:8];
            2'd2: ld_byte = dmem_rdata[23:16];
            2'd3: ld_byte = dmem_rdata[31:24];
            default: ;
        endcase
    end

    assign ld_half = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

    always_comb begin
        load_data = dmem_rdata;
        case (funct3_in[1:0])
            2'b00:   load_data = {{24{~funct3_in[2] & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{~funct3_in[2] & ld_half[15]}}, ld_half};
            default: load_data = dmem_rdata;
        endcase
    end

    always_comb begin
        wb_sel = alu_result_in;
        if (aj_control_in != 2'b00) begin
            wb_sel = pc_plus4_in;
        end else if (memtoreg_in) begin
            wb_sel = load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= 8'd0;
            bus_err     <= 1'b0;
            regwrite_wb <= 1'b0;
            memtoreg_wb <= 1'b0;
            rd_wb       <= 5'd0;
            wb_data     <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (abort) begin
                bus_err <= 1'b1;
            end
            // Stalled, aborted or trapped instructions leave a bubble; wb_data keeps its value.
            if (kill) begin
                regwrite_wb <= 1'b0;
                memtoreg_wb <= 1'b0;
                rd_wb       <= 5'd0;
            end else begin
                regwrite_wb <= regwrite_in;
                memtoreg_wb <= memtoreg_in;
                rd_wb       <= rd_in;
                wb_data     <= wb_sel;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (misalign) begin
            misalign_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed table, random instructions against a
// behavioural model, watchdog abort and mid-wait reset sequences.
module tb_mem_wb_stage;

    localparam int MAX_WAIT = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        memtoreg_in, regwrite_in, memread_in, memwrite_in;
    logic [1:0]  aj_control_in;
    logic [31:0] alu_result_in, store_data_in, pc_plus4_in;
    logic [2:0]  funct3_in;
    logic [4:0]  rd_in;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        stall_out, bus_err, regwrite_wb, memtoreg_wb;
    logic [4:0]  rd_wb;
    logic [31:0] wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_err;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] prev_wb;

    mem_wb_stage dut (
        .clk(clk), .rst(rst),
        .memtoreg_in(memtoreg_in), .regwrite_in(regwrite_in),
        .memread_in(memread_in), .memwrite_in(memwrite_in),
        .aj_control_in(aj_control_in), .alu_result_in(alu_result_in),
        .store_data_in(store_data_in), .funct3_in(funct3_in), .rd_in(rd_in),
        .pc_plus4_in(pc_plus4_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .stall_out(stall_out), .bus_err(bus_err),
        .regwrite_wb(regwrite_wb), .memtoreg_wb(memtoreg_wb),
        .rd_wb(rd_wb), .wb_data(wb_data)
`ifdef MEM_MISALIGN_TRAP_EN
        , .misalign_err(misalign_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish (act=running, req=finished)");
        $fatal(1);
    end

    typedef struct {
        logic        mr, mw, mtr, rw;
        logic [1:0]  aj;
        logic [31:0] alu, sd;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] pc4, rdata;
        int          lat;
        logic [3:0]  e_strb;
        logic [31:0] e_wdata, e_wb;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic mr, logic mw, logic mtr, logic rw, logic [1:0] aj,
                                logic [31:0] alu, logic [31:0] sd, logic [2:0] f3,
                                logic [4:0] rd, logic [31:0] pc4, logic [31:0] rdata,
                                int lat, logic [3:0] strb, logic [31:0] wdata,
                                logic [31:0] wb);
        vec_t v;
        v.mr = mr; v.mw = mw; v.mtr = mtr; v.rw = rw; v.aj = aj; v.alu = alu; v.sd = sd;
        v.f3 = f3; v.rd = rd; v.pc4 = pc4; v.rdata = rdata; v.lat = lat;
        v.e_strb = strb; v.e_wdata = wdata; v.e_wb = wb;
        return v;
    endfunction

    // Behavioural reference: sizes in bytes, lane offsets as byte counts.
    function automatic int size_of(logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic int lane_of(logic [2:0] f3, logic [31:0] a);
        int n = size_of(f3);
        if (n == 4) return 0;
        return (int'(a[1:0]) / n) * n;
    endfunction

    function automatic logic [3:0] model_strb(logic [2:0] f3, logic [31:0] a);
        int n = size_of(f3);
        int m = ((1 << n) - 1) << lane_of(f3, a);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_wdata(logic [2:0] f3, logic [31:0] d);
        int n = size_of(f3);
        if (n == 1) return (d & 32'hFF) * 32'h01010101;
        if (n == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(logic [2:0] f3, logic [31:0] a, logic [31:0] r);
        int n = size_of(f3);
        logic [31:0] v = r >> (8 * lane_of(f3, a));
        logic [31:0] mask;
        if (n == 4) return r;
        mask = (32'd1 << (8 * n)) - 32'd1;
        v = v & mask;
        if (!f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        memtoreg_in = 0; regwrite_in = 0; memread_in = 0; memwrite_in = 0;
        aj_control_in = 0; alu_result_in = 0; store_data_in = 0; funct3_in = 0;
        rd_in = 0; pc_plus4_in = 0; dmem_ack = 0; dmem_rdata = 0;
    endtask

    // Called just after a rising edge; leaves time just after a rising edge.
    task automatic run_vec(input vec_t v);
        logic acc = v.mr | v.mw;
        int n = acc ? v.lat : 0;
        memread_in = v.mr; memwrite_in = v.mw; memtoreg_in = v.mtr; regwrite_in = v.rw;
        aj_control_in = v.aj; alu_result_in = v.alu; store_data_in = v.sd;
        funct3_in = v.f3; rd_in = v.rd; pc_plus4_in = v.pc4;
        for (int c = 0; c <= n; c++) begin
            dmem_ack   = acc && (c == n);
            dmem_rdata = (c == n) ? v.rdata : $urandom;
            @(negedge clk);
            chk("stall", 32'(stall_out), 32'(acc && (c < n)));
            chk("req", 32'(dmem_req), 32'(acc));
            if (acc) chk("addr", dmem_addr, v.alu & ~32'h3);
            if (v.mw) begin
                chk("we", 32'(dmem_we), 32'd1);
                chk("wstrb", 32'(dmem_wstrb), 32'(v.e_strb));
                chk("wdata", dmem_wdata, v.e_wdata);
            end
            @(posedge clk);
            #1;
            if (c < n) begin
                chk("bubble_rw", 32'(regwrite_wb), 32'd0);
                chk("bubble_rd", 32'(rd_wb), 32'd0);
                chk("bubble_hold", wb_data, prev_wb);
            end else begin
                chk("regwrite_wb", 32'(regwrite_wb), 32'(v.rw));
                chk("memtoreg_wb", 32'(memtoreg_wb), 32'(v.mtr));
                chk("rd_wb", 32'(rd_wb), 32'(v.rd));
                chk("wb_data", wb_data, v.e_wb);
                prev_wb = v.e_wb;
            end
        end
        clear_inputs();
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        int kind = $urandom_range(0, 3);
        logic [2:0] lf3[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        v = mk(0, 0, 0, 1, 2'b00, $urandom, $urandom, 3'(lf3[$urandom_range(0, 4)]),
               5'($urandom), $urandom, $urandom, $urandom_range(0, 4), 0, 0, 0);
        if (kind == 3) begin
            v.mw = 1; v.rw = 0; v.f3 = 3'($urandom_range(0, 2));
        end else if (kind == 2) begin
            v.mr = 1; v.mtr = 1;
        end else if (kind == 1) begin
            v.aj = 2'($urandom_range(1, 3)); v.mtr = 1'($urandom);
        end
`ifdef MEM_MISALIGN_TRAP_EN
        if (size_of(v.f3) == 2) v.alu[0] = 1'b0;
        if (size_of(v.f3) == 4) v.alu[1:0] = 2'b00;
`endif
        v.e_strb  = model_strb(v.f3, v.alu);
        v.e_wdata = model_wdata(v.f3, v.sd);
        if (v.aj != 0) v.e_wb = v.pc4;
        else if (v.mtr) v.e_wb = model_load(v.f3, v.alu, v.rdata);
        else v.e_wb = v.alu;
        return v;
    endfunction

    initial begin
        int low_at;
        clear_inputs();
        prev_wb = 0;
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        chk("rst_regwrite_wb", 32'(regwrite_wb), 0);
        chk("rst_memtoreg_wb", 32'(memtoreg_wb), 0);
        chk("rst_rd_wb", 32'(rd_wb), 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_req", 32'(dmem_req), 0);
        chk("rst_bus_err", 32'(bus_err), 0);
        rst = 0;

        tbl.push_back(mk(0,1,0,0,0,'h100,'hDEADBEEF,3'b010,0,'h4,0,3,4'hF,'hDEADBEEF,'h100));
        tbl.push_back(mk(0,1,0,0,0,'h103,'h12345678,3'b000,0,'h8,0,1,4'h8,'h78787878,'h103));
        tbl.push_back(mk(1,0,1,1,0,'h103,0,3'b000,5,'hC,'h80000000,2,0,0,'hFFFFFF80));
        tbl.push_back(mk(1,0,1,1,0,'h102,0,3'b101,6,'h10,'hBEEF0000,0,0,0,'h0000BEEF));
        tbl.push_back(mk(0,0,0,1,2'b01,'h99,0,0,1,'h44,0,0,0,0,'h44));
        tbl.push_back(mk(0,0,0,1,0,'h1234,0,0,2,'h48,0,0,0,0,'h1234));
        tbl.push_back(mk(0,1,0,0,0,'h202,'hABCD1234,3'b001,0,'h50,0,0,4'hC,'h12341234,'h202));
        tbl.push_back(mk(1,0,1,1,0,'h200,0,3'b001,3,0,'h12348001,1,0,0,'hFFFF8001));
        tbl.push_back(mk(1,0,1,1,0,'h104,0,3'b010,4,0,'hCAFEBABE,1,0,0,'hCAFEBABE));
        tbl.push_back(mk(1,0,1,1,0,'h101,0,3'b100,8,0,'h0000F700,2,0,0,'h000000F7));
        tbl.push_back(mk(0,0,0,1,2'b10,'h77,0,0,9,'h80,0,0,0,0,'h80));
        tbl.push_back(mk(0,1,0,0,0,'h101,'h000000AB,3'b000,0,0,0,2,4'h2,'hABABABAB,'h101));
        tbl.push_back(mk(0,0,0,1,0,'h55,0,0,0,0,0,0,0,0,'h55));
`ifndef MEM_MISALIGN_TRAP_EN
        tbl.push_back(mk(1,0,1,1,0,'h101,0,3'b010,10,0,'h11223344,0,0,0,'h11223344));
`endif
        foreach (tbl[i]) run_vec(tbl[i]);

        for (int i = 0; i < 200; i++) run_vec(rand_vec());

        // Watchdog: load that never gets an ack.
        memread_in = 1; memtoreg_in = 1; regwrite_in = 1; funct3_in = 3'b010;
        alu_result_in = 'h300; rd_in = 7; dmem_ack = 0;
        low_at = -1;
        for (int c = 0; c < 300 && low_at < 0; c++) begin
            @(negedge clk);
            if (c == 0) chk("wd_bus_err_before", 32'(bus_err), 0);
            if (!stall_out) low_at = c;
            @(posedge clk);
            #1;
        end
        chk("wd_abort_cycle", 32'(low_at), 32'(MAX_WAIT));
        chk("wd_bus_err", 32'(bus_err), 1);
        chk("wd_regwrite_wb", 32'(regwrite_wb), 0);
        clear_inputs();
        @(negedge clk);
        chk("wd_req_after", 32'(dmem_req), 0);
        chk("wd_bus_err_sticky", 32'(bus_err), 1);
        @(posedge clk); #1;

        // Reset during the second WAIT cycle.
        memread_in = 1; memtoreg_in = 1; regwrite_in = 1; funct3_in = 3'b010;
        alu_result_in = 'h400; rd_in = 11;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        clear_inputs();
        @(negedge clk);
        chk("rstw_req_before", 32'(dmem_req), 1);
        @(posedge clk); #1;
        chk("rstw_req", 32'(dmem_req), 0);
        chk("rstw_bus_err", 32'(bus_err), 0);
        chk("rstw_wb_data", wb_data, 0);
        rst = 0;
        prev_wb = 0;
        run_vec(mk(1,0,1,1,0,'h104,0,3'b010,4,0,'h0BADF00D,3,0,0,'h0BADF00D));

`ifdef MEM_MISALIGN_TRAP_EN
        memread_in = 1; memtoreg_in = 1; regwrite_in = 1; funct3_in = 3'b010;
        alu_result_in = 'h101; rd_in = 12;
        @(negedge clk);
        chk("mis_req", 32'(dmem_req), 0);
        chk("mis_stall", 32'(stall_out), 0);
        @(posedge clk); #1;
        chk("mis_err", 32'(misalign_err), 1);
        chk("mis_regwrite_wb", 32'(regwrite_wb), 0);
        clear_inputs();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
